// File: rtl/eth_rx_pkg.sv
// Shared types and widths for the Ethernet receive sequencing controller.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_RECEIVING = 2'd2,
    ST_DONE      = 2'd3
  } rx_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int BIT_CNT_W   = 15;
  localparam int LEN_W       = 12;

endpackage

// File: rtl/eth_sck_sync.sv
// Brings the PHY serial clock into the clk domain and flags its rising edges.
// Latency: an sck rising edge is seen as a one-cycle pulse ending on the 3rd clk edge; no backpressure.
module eth_sck_sync
  import eth_rx_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sck_in,
  output logic sck_rise
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sck_in};
      edge_q <= sync_q[STAGES-1];
    end
  end

  assign sck_rise = sync_q[STAGES-1] & ~edge_q;

endmodule

// File: rtl/eth_rx_ctrl.sv
// Arms the serial receiver for one frame, counts clocked-in bits and hands the buffer back to the CPU.
// Latency: sck edge counted 3 clk after it; ready IDLE_TIMEOUT clk after the last counted edge; waits on ack.
module eth_rx_ctrl
  import eth_rx_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64,
  parameter int MAX_BYTES    = 2048
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             sck_in,
  input  logic             arm,
  input  logic             ack,
  output logic             rx_n_rst,
  output logic             cpu_sel,
  output logic             busy,
  output logic             ready,
  output logic [LEN_W-1:0] len,
  output logic             overflow,
  output logic             bit_err
);

  localparam int                    IDLE_W    = $clog2(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_MAX   = BIT_CNT_W'(MAX_BYTES * 8);

  rx_state_t             state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  sck_rise;

  eth_sck_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .sck_in   (sck_in),
    .sck_rise (sck_rise)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      rx_n_rst <= 1'b0;
      cpu_sel  <= 1'b1;
      busy     <= 1'b0;
      ready    <= 1'b0;
      len      <= '0;
      overflow <= 1'b0;
      bit_err  <= 1'b0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= ST_ARMED;
            rx_n_rst <= 1'b1;
            cpu_sel  <= 1'b0;
            busy     <= 1'b1;
            len      <= '0;
            overflow <= 1'b0;
            bit_err  <= 1'b0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end
        end
        ST_ARMED: begin
          // The edge that starts the frame is also its first bit.
          if (sck_rise) begin
            state    <= ST_RECEIVING;
            bit_cnt  <= BIT_CNT_W'(1);
            idle_cnt <= '0;
          end
        end
        ST_RECEIVING: begin
          if (sck_rise) begin
            idle_cnt <= '0;
            if (bit_cnt == BIT_MAX) overflow <= 1'b1;
            else                    bit_cnt  <= bit_cnt + 1'b1;
          end else if (idle_cnt == IDLE_LAST) begin
            state    <= ST_DONE;
            rx_n_rst <= 1'b0;
            cpu_sel  <= 1'b1;
            busy     <= 1'b0;
            ready    <= 1'b1;
            // Saturated count caps this at MAX_BYTES, which LEN_W can hold.
            len      <= bit_cnt[BIT_CNT_W-1:3];
            bit_err  <= |bit_cnt[2:0];
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (ack) begin
            state <= ST_IDLE;
            ready <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Randomized frames for eth_rx_ctrl checked against a pulse-count model of the frame rules.
module tb_eth_rx_ctrl;

  localparam int IDLE_TIMEOUT = 64;
  localparam int MAX_BYTES    = 2048;
  localparam int PER          = 10;

  logic        clk    = 1'b0;
  logic        n_rst  = 1'b1;
  logic        sck_in = 1'b0;
  logic        arm    = 1'b0;
  logic        ack    = 1'b0;
  logic        rx_n_rst, cpu_sel, busy, ready, overflow, bit_err;
  logic [11:0] len;

  int     tests = 0;
  int     fails = 0;
  longint last_rise_t = 0;

  eth_rx_ctrl #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .MAX_BYTES(MAX_BYTES)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .sck_in   (sck_in),
    .arm      (arm),
    .ack      (ack),
    .rx_n_rst (rx_n_rst),
    .cpu_sel  (cpu_sel),
    .busy     (busy),
    .ready    (ready),
    .len      (len),
    .overflow (overflow),
    .bit_err  (bit_err)
  );

  always #(PER/2) clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each pulse is hi clk cycles high then lo cycles low, edges offset from clk.
  task automatic send_pulses(input int n, input int hi, input int lo);
    if (n > 0) begin
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
        #3 sck_in = 1'b1;
        last_rise_t = $time;
        repeat (hi) @(posedge clk);
        #3 sck_in = 1'b0;
        repeat (lo) @(posedge clk);
      end
    end
  endtask

  task automatic arm_cpu(input string tag);
    @(negedge clk) arm = 1'b1;
    @(negedge clk) arm = 1'b0;
    chk({tag, "_arm_busy"},  busy,     1);
    chk({tag, "_arm_rxrst"}, rx_n_rst, 1);
    chk({tag, "_arm_sel"},   cpu_sel,  0);
    chk({tag, "_arm_len"},   len,      0);
    chk({tag, "_arm_ovf"},   overflow, 0);
    chk({tag, "_arm_berr"},  bit_err,  0);
  endtask

  // Model: the frame holds n bits, capped at the buffer size in bits.
  task automatic finish_frame(input string tag, input int n, input bit do_ack);
    int c = 0;
    int counted;
    counted = (n > MAX_BYTES * 8) ? MAX_BYTES * 8 : n;
    while (!ready && c < IDLE_TIMEOUT * 4) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, "_done"}, ready, 1);
    if (ready) chk({tag, "_lat"}, $time - 1 - last_rise_t, (3 + IDLE_TIMEOUT) * PER - 3);
    @(negedge clk);
    chk({tag, "_len"},   len,      counted / 8);
    chk({tag, "_ovf"},   overflow, (n > MAX_BYTES * 8) ? 1 : 0);
    chk({tag, "_berr"},  bit_err,  (counted % 8 != 0) ? 1 : 0);
    chk({tag, "_rxrst"}, rx_n_rst, 0);
    chk({tag, "_sel"},   cpu_sel,  1);
    chk({tag, "_busy"},  busy,     0);
    if (do_ack) begin
      ack = 1'b1;
      @(negedge clk) ack = 1'b0;
      chk({tag, "_ack_rdy"}, ready,   0);
      chk({tag, "_ack_sel"}, cpu_sel, 1);
      chk({tag, "_ack_len"}, len,     counted / 8);
    end
  endtask

  task automatic run_frame(input string tag, input int n, input int hi, input int lo, input bit do_ack);
    arm_cpu(tag);
    send_pulses(n, hi, lo);
    finish_frame(tag, n, do_ack);
  endtask

  initial begin
    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state_busy", busy,     0);
    chk("rst_rxrst",      rx_n_rst, 0);
    chk("rst_sel",        cpu_sel,  1);
    chk("rst_ready",      ready,    0);
    chk("rst_len",        len,      0);
    chk("rst_ovf",        overflow, 0);
    chk("rst_berr",       bit_err,  0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    run_frame("f64", 64, 2, 2, 1'b1);
    run_frame("f13", 13, 2, 2, 1'b1);
    run_frame("ovf", MAX_BYTES * 8 + 5, 2, 2, 1'b1);

    // Both arm and ack in DONE: ack wins, arm must come again in IDLE.
    run_frame("aa", 24, 2, 2, 1'b0);
    arm = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    ack = 1'b0;
    chk("aa_ready", ready,    0);
    chk("aa_busy",  busy,     0);
    chk("aa_sel",   cpu_sel,  1);
    chk("aa_rxrst", rx_n_rst, 0);
    repeat (10) @(negedge clk);
    chk("aa_stay_busy", busy, 0);
    chk("aa_stay_len",  len,  3);

    arm_cpu("armrx");
    fork
      send_pulses(100, 2, 3);
      begin
        repeat (40) @(negedge clk);
        arm = 1'b1;
        @(negedge clk) arm = 1'b0;
      end
    join
    finish_frame("armrx", 100, 1'b1);

    // Reset mid-frame, then pulses without an arm must not be counted.
    arm_cpu("mid");
    send_pulses(20, 2, 2);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rxrst", rx_n_rst, 0);
    chk("mid_sel",   cpu_sel,  1);
    chk("mid_busy",  busy,     0);
    chk("mid_ready", ready,    0);
    chk("mid_len",   len,      0);
    @(negedge clk) n_rst = 1'b1;
    send_pulses(10, 2, 2);
    repeat (IDLE_TIMEOUT + 10) @(negedge clk);
    chk("mid_after_busy",  busy,     0);
    chk("mid_after_ready", ready,    0);
    chk("mid_after_rxrst", rx_n_rst, 0);
    chk("mid_after_len",   len,      0);
    run_frame("post", 30, 2, 2, 1'b1);

    arm_cpu("nosck");
    repeat (10 * IDLE_TIMEOUT) @(negedge clk);
    chk("nosck_busy",  busy,     1);
    chk("nosck_ready", ready,    0);
    chk("nosck_rxrst", rx_n_rst, 1);
    chk("nosck_sel",   cpu_sel,  0);
    send_pulses(16, 2, 2);
    finish_frame("nosck", 16, 1'b1);

    for (int t = 0; t < 6; t++) begin
      int n, hi, lo;
      n  = $urandom_range(400, 1);
      hi = $urandom_range(3, 2);
      lo = $urandom_range(3, 2);
      run_frame($sformatf("rnd%0d", t), n, hi, lo, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
